// File: rtl/hazard_stall_unit_if.sv
// Hazard controller bundle: ID/EXE/MEM hazard sources in, pipeline register controls
// and performance counters out.
interface hazard_stall_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             Uses_Rs_ID;
  logic             Uses_Rt_ID;
  logic             Branch_ID;
  logic             Jump_ID;
  logic             Branch_Taken_ID;
  logic [4:0]       RegWr_EXE;
  logic             RegWrite_ID_EXE;
  logic             MemRead_ID_EXE;
  logic [4:0]       RegWr_MEM;
  logic             RegWrite_EXE_MEM;
  logic             MemRead_EXE_MEM;
  logic             Mem_Busy;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EXE_Bubble;
  logic             Pipe_Freeze;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  modport master (
    output Rs_ID, Rt_ID, Uses_Rs_ID, Uses_Rt_ID, Branch_ID, Jump_ID, Branch_Taken_ID,
    output RegWr_EXE, RegWrite_ID_EXE, MemRead_ID_EXE,
    output RegWr_MEM, RegWrite_EXE_MEM, MemRead_EXE_MEM, Mem_Busy,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EXE_Bubble, Pipe_Freeze,
    input  Stall_Count, Flush_Count
  );

  modport slave (
    input  Rs_ID, Rt_ID, Uses_Rs_ID, Uses_Rt_ID, Branch_ID, Jump_ID, Branch_Taken_ID,
    input  RegWr_EXE, RegWrite_ID_EXE, MemRead_ID_EXE,
    input  RegWr_MEM, RegWrite_EXE_MEM, MemRead_EXE_MEM, Mem_Busy,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EXE_Bubble, Pipe_Freeze,
    output Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush/freeze controller for the five-stage MIPS pipeline, with saturating
// stall and flush cycle counters.
module hazard_stall_unit #(
  parameter int unsigned CNT_W = 16
) (
  input logic              Clk,
  input logic              Rst,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic [1:0] {StRun, StStall, StFreeze} state_e;

  state_e           state_q, state_d, saved_q, saved_d, eff_state;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic e_rs, e_rt, m_rs, m_rt, e_hit, m_hit;
  logic [1:0] haz_len;
  logic pc_write, if_id_write, if_id_flush, id_exe_bubble, pipe_freeze;

  assign e_rs = hz.Uses_Rs_ID & hz.RegWrite_ID_EXE & (hz.RegWr_EXE != 5'd0)
              & (hz.RegWr_EXE == hz.Rs_ID);
  assign e_rt = hz.Uses_Rt_ID & hz.RegWrite_ID_EXE & (hz.RegWr_EXE != 5'd0)
              & (hz.RegWr_EXE == hz.Rt_ID);
  assign m_rs = hz.Uses_Rs_ID & hz.RegWrite_EXE_MEM & (hz.RegWr_MEM != 5'd0)
              & (hz.RegWr_MEM == hz.Rs_ID);
  assign m_rt = hz.Uses_Rt_ID & hz.RegWrite_EXE_MEM & (hz.RegWr_MEM != 5'd0)
              & (hz.RegWr_MEM == hz.Rt_ID);
  assign e_hit = e_rs | e_rt;
  assign m_hit = m_rs | m_rt;

  // Branches compare in ID, so they also wait on ALU results and on loads one stage further.
  always_comb begin
    haz_len = 2'd0;
    if (hz.Branch_ID) begin
      if (e_hit & hz.MemRead_ID_EXE) begin
        haz_len = 2'd2;
      end else if (e_hit | (m_hit & hz.MemRead_EXE_MEM)) begin
        haz_len = 2'd1;
      end
    end else if (e_hit & hz.MemRead_ID_EXE) begin
      haz_len = 2'd1;
    end
  end

  // Leaving FREEZE resumes the saved state's rules in the same cycle.
  assign eff_state = (state_q == StFreeze) ? saved_q : state_q;

  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    rem_d         = rem_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    pipe_freeze   = 1'b0;

    if (hz.Mem_Busy) begin
      state_d     = StFreeze;
      saved_d     = eff_state;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else begin
      case (eff_state)
        StStall: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_exe_bubble = 1'b1;
          rem_d         = rem_q - 2'd1;
          state_d       = (rem_q <= 2'd1) ? StRun : StStall;
        end
        default: begin
          state_d = StRun;
          if (haz_len != 2'd0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
            if (haz_len == 2'd2) begin
              rem_d   = 2'd1;
              state_d = StStall;
            end
          end else if (hz.Jump_ID | (hz.Branch_ID & hz.Branch_Taken_ID)) begin
            if_id_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_exe_bubble && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StRun;
      saved_q     <= StRun;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PC_Write      = pc_write;
  assign hz.IF_ID_Write   = if_id_write;
  assign hz.IF_ID_Flush   = if_id_flush;
  assign hz.ID_EXE_Bubble = id_exe_bubble;
  assign hz.Pipe_Freeze   = pipe_freeze;
  assign hz.Stall_Count   = stall_cnt_q;
  assign hz.Flush_Count   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then random traffic,
// checked against a pending-bubble reference model.
module tb_hazard_stall_unit;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) hz();

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .hz  (hz)
  );

  typedef struct {
    bit       rst;
    bit [4:0] rs, rt;
    bit       urs, urt, br, jmp, tkn;
    bit [4:0] rwe;
    bit       rwre, mre;
    bit [4:0] rwm;
    bit       rwrm, mrm, busy;
  } stim_t;

  typedef struct {
    bit          pcw, ifw, fl, bub, frz;
    int unsigned sc, fc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: bubbles still owed, plus the two counters.
  int          m_rem = 0;
  int unsigned m_sc  = 0;
  int unsigned m_fc  = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic int hazard_len(input stim_t s);
    int n = 0;
    bit [4:0] r[2];
    bit u[2];
    bit e, m;
    r[0] = s.rs; r[1] = s.rt;
    u[0] = s.urs; u[1] = s.urt;
    for (int i = 0; i < 2; i++) begin
      if (!u[i]) continue;
      e = s.rwre && (s.rwe != 0) && (s.rwe == r[i]);
      m = s.rwrm && (s.rwm != 0) && (s.rwm == r[i]);
      if (!s.br) begin
        if (e && s.mre) n = (n > 1) ? n : 1;
      end else begin
        if (e) n = (n > (s.mre ? 2 : 1)) ? n : (s.mre ? 2 : 1);
        if (m && s.mrm) n = (n > 1) ? n : 1;
      end
    end
    return n;
  endfunction

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    hz.Rs_ID            = s.rs;
    hz.Rt_ID            = s.rt;
    hz.Uses_Rs_ID       = s.urs;
    hz.Uses_Rt_ID       = s.urt;
    hz.Branch_ID        = s.br;
    hz.Jump_ID          = s.jmp;
    hz.Branch_Taken_ID  = s.tkn;
    hz.RegWr_EXE        = s.rwe;
    hz.RegWrite_ID_EXE  = s.rwre;
    hz.MemRead_ID_EXE   = s.mre;
    hz.RegWr_MEM        = s.rwm;
    hz.RegWrite_EXE_MEM = s.rwrm;
    hz.MemRead_EXE_MEM  = s.mrm;
    hz.Mem_Busy         = s.busy;

    e = '{pcw: 1, ifw: 1, fl: 0, bub: 0, frz: 0, sc: m_sc, fc: m_fc, tag: tag};
    n = hazard_len(s);
    if (s.busy) begin
      e.pcw = 0; e.ifw = 0; e.frz = 1;
    end else if (m_rem > 0) begin
      e.pcw = 0; e.ifw = 0; e.bub = 1;
      m_rem--;
    end else if (n > 0) begin
      e.pcw = 0; e.ifw = 0; e.bub = 1;
      m_rem = n - 1;
    end else if (s.jmp || (s.br && s.tkn)) begin
      e.fl = 1;
    end
    exp_q.push_back(e);

    if (e.bub && m_sc < CntMax) m_sc++;
    if (e.fl && m_fc < CntMax) m_fc++;
    if (s.rst) begin
      m_rem = 0; m_sc = 0; m_fc = 0;
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (hz.PC_Write !== e.pcw || hz.IF_ID_Write !== e.ifw || hz.IF_ID_Flush !== e.fl ||
            hz.ID_EXE_Bubble !== e.bub || hz.Pipe_Freeze !== e.frz ||
            hz.Stall_Count !== CNT_W'(e.sc) || hz.Flush_Count !== CNT_W'(e.fc)) begin
          errors++;
          $display("FAIL %s: got pcw=%b ifw=%b fl=%b bub=%b frz=%b sc=%0d fc=%0d, want pcw=%b ifw=%b fl=%b bub=%b frz=%b sc=%0d fc=%0d",
                   e.tag, hz.PC_Write, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EXE_Bubble,
                   hz.Pipe_Freeze, hz.Stall_Count, hz.Flush_Count,
                   e.pcw, e.ifw, e.fl, e.bub, e.frz, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    stim_t s, ld_br, busy_s, jmp_s;

    rst = 1'b1;
    hz.Rs_ID = '0; hz.Rt_ID = '0; hz.Uses_Rs_ID = 0; hz.Uses_Rt_ID = 0;
    hz.Branch_ID = 0; hz.Jump_ID = 0; hz.Branch_Taken_ID = 0;
    hz.RegWr_EXE = '0; hz.RegWrite_ID_EXE = 0; hz.MemRead_ID_EXE = 0;
    hz.RegWr_MEM = '0; hz.RegWrite_EXE_MEM = 0; hz.MemRead_EXE_MEM = 0; hz.Mem_Busy = 0;
    repeat (2) @(posedge clk);

    step(idle(), "reset_state");

    // Load-use
    s = idle(); s.rwe = 1; s.rwre = 1; s.mre = 1; s.rs = 1; s.urs = 1;
    step(s, "load_use_bubble");
    s = idle(); s.rwm = 1; s.rwrm = 1; s.mrm = 1; s.rs = 1; s.urs = 1;
    step(s, "load_use_resume");

    // Load-to-branch: two bubbles, then the taken branch flushes
    ld_br = idle(); ld_br.rwe = 2; ld_br.rwre = 1; ld_br.mre = 1;
    ld_br.rt = 2; ld_br.urt = 1; ld_br.br = 1; ld_br.tkn = 1;
    step(ld_br, "ld_br_bubble1");
    s = idle(); s.rwm = 2; s.rwrm = 1; s.mrm = 1; s.rt = 2; s.urt = 1; s.br = 1; s.tkn = 1;
    step(s, "ld_br_bubble2");
    s = idle(); s.rt = 2; s.urt = 1; s.br = 1; s.tkn = 1;
    step(s, "ld_br_flush");
    step(idle(), "ld_br_after");

    // ALU-to-branch, then $0 producer
    s = idle(); s.rwe = 3; s.rwre = 1; s.rs = 3; s.urs = 1; s.br = 1;
    step(s, "alu_br_bubble");
    s = idle(); s.rwm = 3; s.rwrm = 1; s.rs = 3; s.urs = 1; s.br = 1;
    step(s, "alu_br_resume");
    s = idle(); s.rwe = 0; s.rwre = 1; s.mre = 1; s.rs = 0; s.urs = 1; s.br = 1;
    step(s, "reg0_no_stall");

    // Freeze mid-stall
    step(ld_br, "frz_enter_stall");
    busy_s = idle(); busy_s.busy = 1; busy_s.jmp = 1;
    repeat (3) step(busy_s, "frz_hold");
    step(idle(), "frz_last_bubble");
    step(idle(), "frz_after");

    // Reset mid-stall
    step(ld_br, "rst_enter_stall");
    s = idle(); s.rst = 1;
    step(s, "rst_in_stall");
    step(idle(), "rst_after");

    // Flush counter saturation
    jmp_s = idle(); jmp_s.jmp = 1;
    for (int i = 0; i < 20; i++) step(jmp_s, "jump_sat");
    step(idle(), "jump_sat_hold");

    // Random traffic with small register numbers so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 59) == 0);
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.urs  = 1'($urandom);
      s.urt  = 1'($urandom);
      s.br   = 1'($urandom);
      s.jmp  = ($urandom_range(0, 3) == 0);
      s.tkn  = 1'($urandom);
      s.rwe  = 5'($urandom_range(0, 3));
      s.rwre = 1'($urandom);
      s.mre  = 1'($urandom);
      s.rwm  = 5'($urandom_range(0, 3));
      s.rwrm = 1'($urandom);
      s.mrm  = 1'($urandom);
      s.busy = ($urandom_range(0, 4) == 0);
      step(s, "random");
    end
    step(idle(), "final");

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
